angle_finder: RTL

//  Inverse of the sine/cosine lookup: given a signed fixed-point value, returns the

---
 rtl/angle_finder.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/angle_finder.sv
// ----------------------------------------------------------------------------
// angle_finder
//   Inverse sine/cosine lookup. Given a signed fixed-point value, returns the
//   integer-degree angle whose sine (op_selector=0) or cosine (op_selector=1)
//   is nearest to it. A fixed-length binary search runs over an internal
//   91-entry quarter-wave sine ROM with a registered read port. A neighbour
//   refinement step follows, then the quadrant mapping. Latency is fixed.
//
// Ports
//   clk          in   1   rising-edge clock
//   rst          in   1   asynchronous active-high reset
//   start        in   1   request, sampled only while idle
//   op_selector  in   1   0 = arcsin, 1 = arccos (captured with start)
//   value        in   32  signed two's complement, FRAC fractional bits
//   busy         out  1   search in progress
//   done         out  1   one-cycle pulse, angle/err valid
//   angle        out  32  result in degrees, held until the next done
//   err          out  1   input magnitude exceeded ONE, held with angle
// ----------------------------------------------------------------------------
module angle_finder #(
    parameter int FRAC = 16,
    parameter int LAT  = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op_selector,
    input  logic [31:0] value,
    output logic        busy,
    output logic        done,
    output logic [31:0] angle,
    output logic        err
);

    localparam logic [31:0] ONE = 32'd1 << FRAC;
    // Capture, neighbour read, neighbour compare and map take 3 cycles;
    // each search iteration takes an address and a compare cycle.
    localparam int SEARCH_ITERS = (LAT - 3) / 2;
    localparam logic [2:0] LAST_ITER = 3'(SEARCH_ITERS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        S_ADDR = 3'd1,
        S_CMP  = 3'd2,
        N_ADDR = 3'd3,
        N_CMP  = 3'd4,
        MAP    = 3'd5
    } state_t;

    // Quarter-wave table, round(sin(d deg) * 2^16); entry 90 is ONE exactly.
    function automatic logic [31:0] rom_lookup(input logic [6:0] idx);
        logic [31:0] q16;
        case (idx)
            7'd0:  q16 = 32'd0;      7'd1:  q16 = 32'd1144;   7'd2:  q16 = 32'd2287;
            7'd3:  q16 = 32'd3430;   7'd4:  q16 = 32'd4572;   7'd5:  q16 = 32'd5712;
            7'd6:  q16 = 32'd6850;   7'd7:  q16 = 32'd7987;   7'd8:  q16 = 32'd9121;
            7'd9:  q16 = 32'd10252;  7'd10: q16 = 32'd11380;  7'd11: q16 = 32'd12505;
            7'd12: q16 = 32'd13626;  7'd13: q16 = 32'd14742;  7'd14: q16 = 32'd15855;
            7'd15: q16 = 32'd16962;  7'd16: q16 = 32'd18064;  7'd17: q16 = 32'd19161;
            7'd18: q16 = 32'd20252;  7'd19: q16 = 32'd21336;  7'd20: q16 = 32'd22415;
            7'd21: q16 = 32'd23486;  7'd22: q16 = 32'd24550;  7'd23: q16 = 32'd25607;
            7'd24: q16 = 32'd26656;  7'd25: q16 = 32'd27697;  7'd26: q16 = 32'd28729;
            7'd27: q16 = 32'd29753;  7'd28: q16 = 32'd30767;  7'd29: q16 = 32'd31772;
            7'd30: q16 = 32'd32768;  7'd31: q16 = 32'd33754;  7'd32: q16 = 32'd34729;
            7'd33: q16 = 32'd35693;  7'd34: q16 = 32'd36647;  7'd35: q16 = 32'd37590;
            7'd36: q16 = 32'd38521;  7'd37: q16 = 32'd39441;  7'd38: q16 = 32'd40348;
            7'd39: q16 = 32'd41243;  7'd40: q16 = 32'd42126;  7'd41: q16 = 32'd42995;
            7'd42: q16 = 32'd43852;  7'd43: q16 = 32'd44695;  7'd44: q16 = 32'd45525;
            7'd45: q16 = 32'd46341;  7'd46: q16 = 32'd47143;  7'd47: q16 = 32'd47930;
            7'd48: q16 = 32'd48703;  7'd49: q16 = 32'd49461;  7'd50: q16 = 32'd50203;
            7'd51: q16 = 32'd50931;  7'd52: q16 = 32'd51643;  7'd53: q16 = 32'd52339;
            7'd54: q16 = 32'd53020;  7'd55: q16 = 32'd53684;  7'd56: q16 = 32'd54332;
            7'd57: q16 = 32'd54963;  7'd58: q16 = 32'd55578;  7'd59: q16 = 32'd56175;
            7'd60: q16 = 32'd56756;  7'd61: q16 = 32'd57319;  7'd62: q16 = 32'd57865;
            7'd63: q16 = 32'd58393;  7'd64: q16 = 32'd58903;  7'd65: q16 = 32'd59396;
            7'd66: q16 = 32'd59870;  7'd67: q16 = 32'd60326;  7'd68: q16 = 32'd60764;
            7'd69: q16 = 32'd61183;  7'd70: q16 = 32'd61584;  7'd71: q16 = 32'd61966;
            7'd72: q16 = 32'd62328;  7'd73: q16 = 32'd62672;  7'd74: q16 = 32'd62997;
            7'd75: q16 = 32'd63303;  7'd76: q16 = 32'd63589;  7'd77: q16 = 32'd63856;
            7'd78: q16 = 32'd64104;  7'd79: q16 = 32'd64332;  7'd80: q16 = 32'd64540;
            7'd81: q16 = 32'd64729;  7'd82: q16 = 32'd64898;  7'd83: q16 = 32'd65048;
            7'd84: q16 = 32'd65177;  7'd85: q16 = 32'd65287;  7'd86: q16 = 32'd65376;
            7'd87: q16 = 32'd65446;  7'd88: q16 = 32'd65496;  7'd89: q16 = 32'd65526;
            7'd90: q16 = 32'd65536;
            default: q16 = 32'd0;
        endcase
        return q16;
    endfunction

    state_t      state_q, state_d;
    logic        op_q, op_d;
    logic        sign_q, sign_d;
    logic        err_pend_q, err_pend_d;
    logic [31:0] a_q, a_d;
    logic [6:0]  lo_q, lo_d;
    logic [6:0]  hi_q, hi_d;
    logic [6:0]  mid_q, mid_d;
    logic [2:0]  iter_q, iter_d;
    logic [31:0] r_hi_q, r_hi_d;
    logic [31:0] rom_q, rom_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] angle_q, angle_d;
    logic        err_q, err_d;

    logic [6:0]  rom_addr_s;
    logic [7:0]  mid_sum_s;
    logic [31:0] abs_s;
    logic        range_err_s;

    // Next-state and datapath logic for the whole search sequence.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        sign_d     = sign_q;
        err_pend_d = err_pend_q;
        a_d        = a_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        mid_d      = mid_q;
        iter_d     = iter_q;
        r_hi_d     = r_hi_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        angle_d    = angle_q;
        err_d      = err_q;
        rom_addr_s = 7'd0;

        // lo+hi can reach 180, so the midpoint sum needs an extra bit.
        mid_sum_s   = {1'b0, lo_q} + {1'b0, hi_q};
        abs_s       = value[31] ? (32'd0 - value) : value;
        // 0x80000000 negates to itself, which is already above ONE.
        range_err_s = (abs_s > ONE);

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d       = op_selector;
                    sign_d     = value[31];
                    err_pend_d = range_err_s;
                    a_d        = range_err_s ? ONE : abs_s;
                    lo_d       = 7'd0;
                    hi_d       = 7'd90;
                    mid_d      = 7'd0;
                    iter_d     = 3'd0;
                    r_hi_d     = ONE;
                    busy_d     = 1'b1;
                    state_d    = S_ADDR;
                end else begin
                    state_d = IDLE;
                end
            end
            S_ADDR: begin
                rom_addr_s = mid_sum_s[7:1];
                mid_d      = mid_sum_s[7:1];
                state_d    = S_CMP;
            end
            S_CMP: begin
                // Once the interval has collapsed the remaining iterations idle,
                // keeping the latency fixed.
                if (lo_q < hi_q) begin
                    if (rom_q >= a_q) begin
                        hi_d   = mid_q;
                        r_hi_d = rom_q;
                    end else begin
                        lo_d = mid_q + 7'd1;
                    end
                end else begin
                    lo_d = lo_q;
                end
                iter_d = iter_q + 3'd1;
                if (iter_q == LAST_ITER) begin
                    state_d = N_ADDR;
                end else begin
                    state_d = S_ADDR;
                end
            end
            N_ADDR: begin
                // lo == hi == d here; r_hi already holds rom[d].
                rom_addr_s = (lo_q == 7'd0) ? 7'd0 : (lo_q - 7'd1);
                state_d    = N_CMP;
            end
            N_CMP: begin
                // Step down only when the lower neighbour is strictly closer.
                if ((lo_q != 7'd0) && ((r_hi_q - a_q) > (a_q - rom_q))) begin
                    lo_d = lo_q - 7'd1;
                end else begin
                    lo_d = lo_q;
                end
                state_d = MAP;
            end
            MAP: begin
                if (op_q == 1'b0) begin
                    if (sign_q == 1'b0) begin
                        angle_d = {25'd0, lo_q};
                    end else if (lo_q == 7'd0) begin
                        angle_d = 32'd0;
                    end else begin
                        angle_d = 32'd360 - {25'd0, lo_q};
                    end
                end else begin
                    if (sign_q == 1'b0) begin
                        angle_d = 32'd90 - {25'd0, lo_q};
                    end else begin
                        angle_d = 32'd90 + {25'd0, lo_q};
                    end
                end
                err_d   = err_pend_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase

        rom_d = rom_lookup(rom_addr_s);
    end

    // State, search registers, ROM read register and outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= 1'b0;
            sign_q     <= 1'b0;
            err_pend_q <= 1'b0;
            a_q        <= 32'd0;
            lo_q       <= 7'd0;
            hi_q       <= 7'd0;
            mid_q      <= 7'd0;
            iter_q     <= 3'd0;
            r_hi_q     <= 32'd0;
            rom_q      <= 32'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            angle_q    <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            sign_q     <= sign_d;
            err_pend_q <= err_pend_d;
            a_q        <= a_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            mid_q      <= mid_d;
            iter_q     <= iter_d;
            r_hi_q     <= r_hi_d;
            rom_q      <= rom_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            angle_q    <= angle_d;
            err_q      <= err_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign angle = angle_q;
    assign err   = err_q;

endmodule
